// File: rtl/gen_for_seq.sv
// Sequential GenForEnt accumulator: one shared add/sub unit is reused over COUNT
// cycles, with valid/ready handshakes on the operand and result sides.
module gen_for_seq #(
    parameter int NBITS  = 8,
    parameter int COUNT  = 4,
    parameter int INIT   = 1,
    parameter int OFFSET = 17
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [NBITS-1:0] A,
    input  logic [NBITS-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [NBITS-1:0] XOUT,
    output logic             BUSY,
    output logic [7:0]       ITER
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [NBITS-1:0] INIT_V    = NBITS'(INIT);
    localparam logic [NBITS-1:0] OFFSET_V  = NBITS'(OFFSET);
    localparam logic [7:0]       LAST_ITER = 8'(COUNT - 1);

    logic [1:0]       r_state;
    logic [NBITS-1:0] r_acc;
    logic [7:0]       r_iter;
    logic [NBITS-1:0] r_a;
    logic [NBITS-1:0] r_b;
    logic [NBITS-1:0] r_xout;
    logic             r_outValid;

    logic [NBITS-1:0] w_term;
    logic [NBITS-1:0] w_sum;

    // Even iterations add A+B, odd iterations add A-B; both wrap mod 2^NBITS.
    assign w_term = r_iter[0] ? (r_a - r_b) : (r_a + r_b);
    assign w_sum  = r_acc + w_term;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_iter     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_xout     <= '0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_acc   <= INIT_V;
                        r_iter  <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_sum;
                    if (r_iter == LAST_ITER) begin
                        r_xout     <= w_sum - OFFSET_V;
                        r_outValid <= 1'b1;
                        r_iter     <= '0;
                        r_state    <= S_DONE;
                    end else begin
                        r_iter <= r_iter + 8'd1;
                    end
                end
                S_DONE: begin
                    if (OUT_READY) begin
                        r_outValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign IN_READY  = (r_state == S_IDLE);
    assign BUSY      = (r_state == S_RUN);
    assign OUT_VALID = r_outValid;
    assign XOUT      = r_xout;
    assign ITER      = r_iter;

endmodule

// File: tb/tb_gen_for_seq.sv
// Bench for gen_for_seq: a default-parameter instance and a COUNT=1 corner instance
// share the stimulus and are checked every cycle against a transaction-level model.
module tb_gen_for_seq;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       IN_VALID = 1'b0;
    logic [7:0] A = 8'd0;
    logic [7:0] B = 8'd0;
    logic       OUT_READY = 1'b1;

    logic       inReady  [2];
    logic       outValid [2];
    logic       busy     [2];
    logic [7:0] xout     [2];
    logic [7:0] iter     [2];

    int nPass  = 0;
    int nTotal = 0;

    // Per-instance parameters used by the model
    int cnt  [2] = '{4, 1};
    int ini  [2] = '{1, 0};
    int offs [2] = '{17, 0};

    int         mBusyLeft [2] = '{0, 0};
    logic       mWaiting  [2] = '{1'b0, 1'b0};
    logic [7:0] mPend     [2] = '{8'd0, 8'd0};
    logic [7:0] mXout     [2] = '{8'd0, 8'd0};

    gen_for_seq #(.NBITS(8), .COUNT(4), .INIT(1), .OFFSET(17)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(inReady[0]),
        .A(A), .B(B), .OUT_VALID(outValid[0]), .OUT_READY(OUT_READY),
        .XOUT(xout[0]), .BUSY(busy[0]), .ITER(iter[0])
    );

    gen_for_seq #(.NBITS(8), .COUNT(1), .INIT(0), .OFFSET(0)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(inReady[1]),
        .A(A), .B(B), .OUT_VALID(outValid[1]), .OUT_READY(OUT_READY),
        .XOUT(xout[1]), .BUSY(busy[1]), .ITER(iter[1])
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] expectedResult(input logic [7:0] a, input logic [7:0] b,
                                                  input int n, input int i0, input int off);
        int ai = int'(a);
        int bi = int'(b);
        int acc = i0;
        for (int i = 0; i < n; i++) acc += (i % 2 == 0) ? (ai + bi) : (ai - bi);
        return 8'(acc - off);
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        nTotal++;
        if (act == exp) nPass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a result becomes visible COUNT edges after accept and waits for OUT_READY
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int d = 0; d < 2; d++) begin
                mBusyLeft[d] <= 0;
                mWaiting[d]  <= 1'b0;
                mXout[d]     <= 8'd0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (mBusyLeft[d] > 0) begin
                    mBusyLeft[d] <= mBusyLeft[d] - 1;
                    if (mBusyLeft[d] == 1) begin
                        mWaiting[d] <= 1'b1;
                        mXout[d]    <= mPend[d];
                    end
                end else if (mWaiting[d]) begin
                    if (OUT_READY) mWaiting[d] <= 1'b0;
                end else if (IN_VALID) begin
                    mBusyLeft[d] <= cnt[d];
                    mPend[d]     <= expectedResult(A, B, cnt[d], ini[d], offs[d]);
                end
            end
        end
    end

    always @(negedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("cmp%0d.inReady", d), int'(inReady[d]),
                        int'(mBusyLeft[d] == 0 && !mWaiting[d]));
            checkOutput($sformatf("cmp%0d.busy", d), int'(busy[d]), int'(mBusyLeft[d] > 0));
            checkOutput($sformatf("cmp%0d.iter", d), int'(iter[d]),
                        (mBusyLeft[d] > 0) ? cnt[d] - mBusyLeft[d] : 0);
            checkOutput($sformatf("cmp%0d.outValid", d), int'(outValid[d]), int'(mWaiting[d]));
            checkOutput($sformatf("cmp%0d.xout", d), int'(xout[d]), int'(mXout[d]));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                                 input logic rdy);
        IN_VALID  = v;
        A         = a;
        B         = b;
        OUT_READY = rdy;
    endtask

    task automatic waitValid0(input string name);
        int n = 0;
        while (!outValid[0] && n < 20) begin
            tick();
            n++;
        end
        checkOutput({name, ".valid"}, int'(outValid[0]), 1);
    endtask

    task automatic runTxn(input logic [7:0] a, input logic [7:0] b, input int expX,
                          input string name);
        applyStimulus(1'b1, a, b, 1'b1);
        tick();
        applyStimulus(1'b0, a, b, 1'b1);
        waitValid0(name);
        checkOutput({name, ".xout"}, int'(xout[0]), expX);
        tick();
        checkOutput({name, ".inReady"}, int'(inReady[0]), 1);
    endtask

    initial begin
        #1;
        checkOutput("reset.inReady", int'(inReady[0]), 1);
        checkOutput("reset.outValid", int'(outValid[0]), 0);
        checkOutput("reset.busy", int'(busy[0]), 0);
        checkOutput("reset.xout", int'(xout[0]), 0);
        repeat (2) @(posedge CLK);
        #2 RST_N = 1'b1;
        tick();

        // Basic: result appears exactly four edges after accept
        applyStimulus(1'b1, 8'd5, 8'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("basic.latency%0d", i), int'(outValid[0]), int'(i == 4));
        end
        checkOutput("basic.xout", int'(xout[0]), 4);
        tick();
        checkOutput("basic.inReady", int'(inReady[0]), 1);
        tick();

        runTxn(8'd200, 8'd100, 16, "wrap");
        runTxn(8'd0, 8'd1, 240, "underflow");

        // Backpressure with operands toggling while the result is held
        applyStimulus(1'b1, 8'd5, 8'd3, 1'b0);
        tick();
        for (int i = 0; i < 20 && !outValid[0]; i++) begin
            applyStimulus(1'b1, 8'(i * 37 + 1), 8'(i * 11 + 2), 1'b0);
            tick();
        end
        checkOutput("bp.valid", int'(outValid[0]), 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(i * 53), 8'(i * 29 + 7), 1'b0);
            tick();
            checkOutput("bp.xoutHeld", int'(xout[0]), 4);
            checkOutput("bp.inReadyLow", int'(inReady[0]), 0);
        end
        applyStimulus(1'b1, 8'd200, 8'd100, 1'b1);
        tick();
        checkOutput("bp.released", int'(inReady[0]), 1);
        tick();
        checkOutput("bp.nextAccepted", int'(busy[0]), 1);
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
        waitValid0("bp.next");
        checkOutput("bp.nextXout", int'(xout[0]), 16);
        tick();
        tick();

        // Asynchronous reset between edges while ITER==2
        applyStimulus(1'b1, 8'd9, 8'd4, 1'b1);
        tick();
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
        for (int i = 0; i < 10 && iter[0] != 8'd2; i++) tick();
        checkOutput("rst.iterReached", int'(iter[0]), 2);
        #1 RST_N = 1'b0;
        #1;
        checkOutput("rst.outValid", int'(outValid[0]), 0);
        checkOutput("rst.busy", int'(busy[0]), 0);
        checkOutput("rst.xout", int'(xout[0]), 0);
        checkOutput("rst.iter", int'(iter[0]), 0);
        @(posedge CLK);
        #2 RST_N = 1'b1;
        tick();
        runTxn(8'd5, 8'd3, 4, "rst.after");

        // COUNT=1 corner instance: busy exactly one cycle, XOUT = A+B
        applyStimulus(1'b1, 8'd7, 8'd9, 1'b1);
        tick();
        applyStimulus(1'b0, 8'd0, 8'd0, 1'b1);
        checkOutput("corner.busy", int'(busy[1]), 1);
        tick();
        checkOutput("corner.busyDone", int'(busy[1]), 0);
        checkOutput("corner.valid", int'(outValid[1]), 1);
        checkOutput("corner.xout", int'(xout[1]), 16);
        for (int i = 0; i < 10 && !inReady[0]; i++) tick();
        checkOutput("corner.drain", int'(inReady[0]), 1);
        tick();

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/gen_for_seq.md
Name: gen_for_seq

Overview:
- Sequential controller that time-multiplexes one shared add/sub unit to evaluate the GenForEnt accumulation over COUNT clock cycles, instead of unrolling it combinationally.
- Result: XOUT = INIT + sum over i<COUNT of (i even ? A+B : A-B) − OFFSET, modulo 2^NBITS.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on both sides.

Parameters:
- NBITS, 8, width of operands, accumulator and result.
- COUNT, 4, number of accumulate iterations; legal range 1..255.
- INIT, 1, accumulator value loaded on operand accept.
- OFFSET, 17, constant subtracted from the accumulator to form XOUT.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  operands A/B are valid.
- IN_READY  out  1  block can accept operands.
- A  in  NBITS  operand A, unsigned.
- B  in  NBITS  operand B, unsigned.
- OUT_VALID  out  1  XOUT holds a result.
- OUT_READY  in  1  consumer accepts the result.
- XOUT  out  NBITS  result, unsigned.
- BUSY  out  1  high in RUN state.
- ITER  out  8  current iteration index.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, acc=0, iter=0, captured A/B=0, XOUT=0, OUT_VALID=0, BUSY=0, ITER=0, IN_READY=1 once the FSM is in IDLE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID=1, capture A and B, set acc=INIT and iter=0, then go to RUN.
  - IN_VALID=0 holds IDLE.
- RUN:
  - IN_READY=0, BUSY=1.
  - Each cycle: acc <= acc + (iter[0]==0 ? Ar+Br : Ar−Br), iter <= iter+1.
  - All arithmetic is NBITS wide and wraps mod 2^NBITS; A−B underflow wraps.
  - On the cycle iter==COUNT−1, the final add is done, XOUT is registered as (acc+term) − OFFSET mod 2^NBITS, OUT_VALID is set to 1, and the FSM goes to DONE.
  - Changes on the A/B inputs during RUN have no effect; only the captured Ar/Br are used.
- DONE:
  - OUT_VALID=1, and XOUT is held stable until the handshake completes.
  - On OUT_READY=1, clear OUT_VALID and go to IDLE.
  - OUT_READY=0 stalls indefinitely.
- Latency and throughput:
  - OUT_VALID rises COUNT cycles after the accept edge.
  - IN_READY returns 1 the cycle after the output handshake.
  - Max throughput: one result per COUNT+2 cycles.
- No simultaneous accept and deliver: IN_READY is 0 in DONE.
- ITER mirrors iter; it reads 0 in IDLE and DONE.
- XOUT keeps the last result after leaving DONE until the next result overwrites it.
- Reset mid-RUN or mid-DONE: immediate return to the reset state; the partial result is discarded and no OUT_VALID pulse is produced.
- COUNT=1: RUN lasts one cycle; XOUT = INIT + A + B − OFFSET.
- OUT_READY asserted before OUT_VALID has no effect.

Test Plan:
- Basic:
  - Stimulus: A=5, B=3, default params, OUT_READY=1.
  - Response: OUT_VALID 4 cycles after accept; XOUT=4 (1+8+2+8+2−17); IN_READY high one cycle later.
- Wrap-around:
  - Stimulus: A=200, B=100.
  - Response: XOUT=16 (A+B=44 mod 256; 1+44+100+44+100=289→33; 33−17=16).
- Underflow:
  - Stimulus: A=0, B=1.
  - Response: terms 1, 255, 1, 255; acc=1+1+255+1+255=513→1; XOUT=1−17=240.
- Backpressure:
  - Stimulus: OUT_READY=0 for 10 cycles after OUT_VALID; toggle A/B and hold IN_VALID=1 meanwhile.
  - Response: XOUT stays stable and IN_READY=0 throughout; the result is accepted once OUT_READY=1; the next operands are accepted the following cycle.
- Reset mid-operation:
  - Stimulus: assert RST_N=0 asynchronously at ITER=2 (between clock edges).
  - Response: OUT_VALID=0, BUSY=0, XOUT=0 immediately; after release, A=5, B=3 yields XOUT=4 normally.
- Parameter corner:
  - Stimulus: COUNT=1, INIT=0, OFFSET=0, A=7, B=9.
  - Response: XOUT=16 one cycle after accept; BUSY high exactly one cycle.
